// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-memory fetch controller.
package imem_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_ERROR = 2'd3
    } fetch_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OVF      = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;

    localparam logic [31:0] PC_INC       = 32'd4;
    localparam int          DEPTH_DEF    = 128;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot stream handshake: writes accepted words into instruction memory,
// tracks image length and flags an image that would overrun the memory.
module imem_boot_loader
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              clear,
    input  logic              ld_valid,
    input  logic              ld_last,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   load_count,
    output logic              done,
    output logic              ovf
);

    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              hs;

    always_ff @(posedge clk) begin
        if (reset) begin
            waddr_q <= '0;
            count_q <= '0;
        end else begin
            waddr_q <= waddr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        hs      = active & ld_valid;
        waddr_d = waddr_q;
        count_d = count_q;
        if (clear) begin
            waddr_d = '0;
            count_d = '0;
        end else if (hs) begin
            waddr_d = waddr_q + 1'b1;
            count_d = count_q + 1'b1;
        end
    end

    assign ld_ready   = active;
    assign mem_we     = hs;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = ld_data;
    assign load_count = count_q;
    assign done       = hs & ld_last;
    // The last slot may still be written; only a missing ld_last there overflows.
    assign ovf        = hs & ~ld_last & (waddr_q == ADDR_W'(DEPTH - 1));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: boot-loads the image, then owns the PC
// (sequential fetch, stall, redirect, halt past image, reload).
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int          DEPTH    = DEPTH_DEF,
    parameter int          ADDR_W   = 7,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       pc,
    output logic              core_en,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              reload,
    output logic              boot_done,
    output logic              halted,
    output logic              err,
    output logic [1:0]        err_code
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [1:0]   err_code_q, err_code_d;
    logic [31:0]  npc;
    logic [ADDR_W:0] load_count;
    logic         ld_done, ld_ovf, ld_clear, in_boot;

    assign in_boot  = (state_q == ST_BOOT);
    assign ld_clear = reload & ~in_boot;

    imem_boot_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk        (clk),
        .reset      (reset),
        .active     (in_boot),
        .clear      (ld_clear),
        .ld_valid   (ld_valid),
        .ld_last    (ld_last),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .load_count (load_count),
        .done       (ld_done),
        .ovf        (ld_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        err_code_d = err_code_q;
        npc        = pc_q + PC_INC;
        unique case (state_q)
            ST_BOOT: begin
                if (ld_done) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end else if (ld_ovf) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_OVF;
                end
            end
            ST_RUN: begin
                if (reload) begin
                    state_d = ST_BOOT;
                    pc_d    = RESET_PC;
                end else if (redirect && redirect_pc[1:0] != 2'b00) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_MISALIGN;
                end else begin
                    if (redirect)   npc = redirect_pc;
                    else if (stall) npc = pc_q;
                    pc_d = npc;
                    // Wrapped pc+4 lands at a low index only if the image is empty.
                    if (npc[31:2] >= 30'(load_count)) state_d = ST_HALT;
                end
            end
            ST_HALT, ST_ERROR: begin
                if (reload) begin
                    state_d    = ST_BOOT;
                    pc_d       = RESET_PC;
                    err_code_d = ERR_NONE;
                end
            end
        endcase
    end

    always_comb begin
        pc        = pc_q;
        core_en   = (state_q == ST_RUN);
        boot_done = (state_q == ST_RUN) || (state_q == ST_HALT);
        halted    = (state_q == ST_HALT);
        err       = (err_code_q != ERR_NONE);
        err_code  = err_code_q;
    end

endmodule
